m16_alu_sequencer: RTL

Request/response sequencer for the M16 packed-SIMD adder. It accepts one ADD, SUB or horizontal-sum (HSUM) request at a time over a valid/ready handshake. It configures the 4×8-bit lane adder for the requested lane width and saturation mode, then runs single-cycle or multi-step reduction sequences. It returns a registered result with per-lane overflow flags. It sits between instruction decode and the writeback stage.

---
 rtl/m16_pkg.sv | 47 ++++
 rtl/m16_lane_adder.sv | 43 ++++
 rtl/m16_alu_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/m16_pkg.sv
// m16_pkg: shared types, constants and helpers for the M16 SIMD adder.
// HSUM reduction support is selected with the M16_SEQ_HSUM_EN macro.
package m16_pkg;

    localparam int LANES  = 4;
    localparam int SLOT_W = 8;
    localparam int DATA_W = LANES * SLOT_W;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_HSUM, OP_RSV} op_e;
    typedef enum logic [1:0] {W8, W16, W32, WILL} width_e;
    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_RED1, S_RED2, S_RESP
    } state_e;

    function automatic logic slot_first(input width_e w, input int i);
        case (w)
            W16:     return (i % 2) == 0;
            W32:     return i == 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic slot_last(input width_e w, input int i);
        case (w)
            W16:     return (i % 2) == 1;
            W32:     return i == LANES - 1;
            default: return 1'b1;
        endcase
    endfunction

    // Top slot of a group carries 0x7F/0x80, lower slots 0xFF/0x00.
    function automatic logic [SLOT_W-1:0] sat_slot(input logic top,
                                                   input logic neg);
        if (top)
            return neg ? 8'h80 : 8'h7F;
        return neg ? 8'h00 : 8'hFF;
    endfunction

    function automatic logic [15:0] sext16(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [31:0] sext32(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/m16_lane_adder.sv
// m16_lane_adder: combinational 4x8-bit adder with width-grouped carries.
// Overflow is signed overflow of each group, flagged at its top slot.
module m16_lane_adder
    import m16_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  width_e            width,
    input  logic              carry_in,
    output logic [DATA_W-1:0] sum,
    output logic [LANES-1:0]  carry_out,
    output logic [LANES-1:0]  ovf
);

    logic              c;
    logic [SLOT_W:0]   s;
    logic [SLOT_W-1:0] sa;
    logic [SLOT_W-1:0] sb;

    always_comb begin
        sum       = '0;
        carry_out = '0;
        ovf       = '0;
        c         = carry_in;
        s         = '0;
        sa        = '0;
        sb        = '0;
        for (int i = 0; i < LANES; i++) begin
            sa = a[i*SLOT_W +: SLOT_W];
            sb = b[i*SLOT_W +: SLOT_W];
            if (slot_first(width, i))
                c = carry_in;
            s = {1'b0, sa} + {1'b0, sb} + {{SLOT_W{1'b0}}, c};
            sum[i*SLOT_W +: SLOT_W] = s[SLOT_W-1:0];
            carry_out[i] = s[SLOT_W];
            if (slot_last(width, i))
                ovf[i] = (sa[SLOT_W-1] == sb[SLOT_W-1]) &&
                         (s[SLOT_W-1] != sa[SLOT_W-1]);
            c = s[SLOT_W];
        end
    end

endmodule

// File: rtl/m16_alu_sequencer.sv
// m16_alu_sequencer: valid/ready sequencer around m16_lane_adder.
// Define M16_SEQ_HSUM_EN to build HSUM and its RED1/RED2 reduction.
module m16_alu_sequencer
    import m16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_width,
    input  logic        req_sat,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_ovf,
    output logic        rsp_err
);

    state_e            state_q, state_d;
    op_e               op_q;
    width_e            width_q;
    logic              sat_q;
    logic [DATA_W-1:0] a_q, b_q;

    logic [DATA_W-1:0] add_a, add_b, add_sum;
    width_e            add_w;
    logic              add_cin;
    logic [LANES-1:0]  add_ovf, unused_cout;

    logic [DATA_W-1:0] res_data;
    logic [LANES-1:0]  res_ovf, grp_ovf, grp_neg;
    logic              res_err, bad, hsum_ok, hsum8;

`ifdef M16_SEQ_HSUM_EN
    assign hsum_ok = 1'b1;
`else
    assign hsum_ok = 1'b0;
`endif
    assign hsum8 = hsum_ok && req_op == OP_HSUM && req_width == W8;
    assign bad = op_q == OP_RSV || width_q == WILL ||
                 (op_q == OP_HSUM && !hsum_ok);

    assign req_ready = state_q == S_IDLE;
    assign rsp_valid = state_q == S_RESP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = hsum8 ? S_RED1 : S_EXEC;
            S_EXEC: state_d = S_RESP;
`ifdef M16_SEQ_HSUM_EN
            S_RED1: state_d = S_RED2;
            S_RED2: state_d = S_RESP;
`endif
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // HSUM reuses a_q: RED1 overwrites it with the two 16-bit partials.
    always_comb begin
        add_a   = a_q;
        add_b   = b_q;
        add_w   = width_q;
        add_cin = 1'b0;
        if (op_q == OP_SUB) begin
            add_b   = ~b_q;
            add_cin = 1'b1;
        end
`ifdef M16_SEQ_HSUM_EN
        if (op_q == OP_HSUM) begin
            add_a = sext32(a_q[31:16]);
            add_b = sext32(a_q[15:0]);
            add_w = W32;
            if (state_q == S_RED1) begin
                add_a = {sext16(a_q[31:24]), sext16(a_q[15:8])};
                add_b = {sext16(a_q[23:16]), sext16(a_q[7:0])};
                add_w = W16;
            end
        end
`endif
    end

    m16_lane_adder u_adder (
        .a         (add_a),
        .b         (add_b),
        .width     (add_w),
        .carry_in  (add_cin),
        .sum       (add_sum),
        .carry_out (unused_cout),
        .ovf       (add_ovf)
    );

    always_comb begin
        res_data = '0;
        res_ovf  = '0;
        res_err  = 1'b0;
        case (width_q)
            W16: begin
                grp_ovf = {{2{add_ovf[3]}}, {2{add_ovf[1]}}};
                grp_neg = {{2{a_q[31]}}, {2{a_q[15]}}};
            end
            W32: begin
                grp_ovf = {LANES{add_ovf[3]}};
                grp_neg = {LANES{a_q[31]}};
            end
            default: begin
                grp_ovf = add_ovf;
                grp_neg = {a_q[31], a_q[23], a_q[15], a_q[7]};
            end
        endcase
        if (bad) begin
            res_err = 1'b1;
        end else if (op_q == OP_HSUM) begin
            res_data = (width_q == W32) ? a_q : add_sum;
        end else begin
            res_ovf = add_ovf;
            for (int i = 0; i < LANES; i++)
                res_data[i*SLOT_W +: SLOT_W] = (sat_q && grp_ovf[i]) ?
                    sat_slot(slot_last(width_q, i), grp_neg[i]) :
                    add_sum[i*SLOT_W +: SLOT_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_ADD;
            width_q  <= W8;
            sat_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rsp_data <= '0;
            rsp_ovf  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (state_q == S_IDLE && req_valid) begin
                op_q    <= op_e'(req_op);
                width_q <= width_e'(req_width);
                sat_q   <= req_sat;
                a_q     <= req_a;
                b_q     <= req_b;
            end
`ifdef M16_SEQ_HSUM_EN
            if (state_q == S_RED1)
                a_q <= add_sum;
`endif
            if (state_q == S_EXEC || state_q == S_RED2) begin
                rsp_data <= res_data;
                rsp_ovf  <= res_ovf;
                rsp_err  <= res_err;
            end
        end
    end

endmodule
